// File: rtl/gate_arb_pkg.sv
// Shared definitions for the gate unit arbiter: opcode constants, FSM state
// encoding and the per-bit evaluation of the shared gate datapath.
package gate_arb_pkg;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_NAND = 2'b10;
   localparam logic [1:0] OP_XOR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_EXEC  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // One bit slice of the gate unit; the caller loops over WIDTH.
   function automatic logic gate_bit(input logic [1:0] op, input logic a, input logic b);
      logic r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_NAND: r = ~(a & b);
         default: r = a ^ b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gate_unit_arbiter_if.sv
// Requester/response bundle of the gate unit arbiter.
//   master : requester side (drives req/op/a/b and rsp_ready)
//   slave  : arbiter side (drives gnt, rsp_valid/id/data, busy)
interface gate_unit_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) ();
   logic [N_REQ-1:0]       req;
   logic [2*N_REQ-1:0]     op;
   logic [WIDTH*N_REQ-1:0] a;
   logic [WIDTH*N_REQ-1:0] b;
   logic [N_REQ-1:0]       gnt;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [WIDTH-1:0]       rsp_data;
   logic                   busy;

   modport master (
      output req, op, a, b, rsp_ready,
      input  gnt, rsp_valid, rsp_id, rsp_data, busy
   );

   modport slave (
      input  req, op, a, b, rsp_ready,
      output gnt, rsp_valid, rsp_id, rsp_data, busy
   );
endinterface

// File: rtl/gate_unit_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit at or
// after ptr_i, wrapping modulo N_REQ.
//   req_i   : request vector
//   ptr_i   : search start index
//   found_o : any request set
//   idx_o   : winning index (0 when nothing found)
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDW-1:0]   ptr_i,
   output logic             found_o,
   output logic [IDW-1:0]   idx_o
);

   int j;

   // Scan from farthest to nearest so the nearest set bit is written last.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      j       = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = int'(ptr_i) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (req_i[j]) begin
            found_o = 1'b1;
            idx_o   = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin sequencer sharing one bitwise gate unit among N_REQ requesters.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : requester requests/operands in, grant and response handshake out
//
// state  | meaning
// IDLE   | waiting for any request; winner picked and registered
// GRANT  | one-hot gnt to winner; its op/a/b captured at cycle end
// EXEC   | result computed from captured operands and registered
// RESP   | rsp_valid held until rsp_ready; pointer then moves past winner
module gate_unit_arbiter
   import gate_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   gate_unit_arbiter_if.slave bus
);

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   win_q, win_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             pick_found;
   logic [IDW-1:0]   pick_idx;

   rr_picker #(.N_REQ(N_REQ), .IDW(IDW)) u_picker (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               win_d   = pick_idx;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            op_d    = bus.op[2*win_q +: 2];
            a_d     = bus.a[WIDTH*win_q +: WIDTH];
            b_d     = bus.b[WIDTH*win_q +: WIDTH];
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            for (int i = 0; i < WIDTH; i++) begin
               data_d[i] = gate_bit(op_q, a_q[i], b_q[i]);
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               // Winner becomes lowest priority for the next pick.
               if (win_q == IDW'(N_REQ - 1)) ptr_d = '0;
               else                          ptr_d = win_q + 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.gnt       = (state_q == ST_GRANT) ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_q) : '0;
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_id    = win_q;
   assign bus.rsp_data  = data_q;
   assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gate_unit_arbiter.sv
module tb_gate_unit_arbiter;
   import gate_arb_pkg::*;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   gate_unit_arbiter_if #(.N_REQ(N), .WIDTH(W), .IDW(IW)) bus ();

   gate_unit_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: m_age counts cycles since the request was
   // accepted (0 = idle), so gnt is at age 1 and the response from age 3 on.
   int             m_age = 0;
   int             m_ptr = 0;
   int             m_win = 0;
   int             m_op  = 0;
   logic [W-1:0]   m_a, m_b;
   logic [W-1:0]   m_data = '0;
   bit             m_on  = 1'b0;

   function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] x, input logic [W-1:0] y);
      case (op)
         0:       return x & y;
         1:       return x | y;
         2:       return ~(x & y);
         default: return x ^ y;
      endcase
   endfunction

   always @(negedge clk) begin
      if (m_on) begin
         chk("model_gnt",       32'(bus.gnt),       (m_age == 1) ? (32'd1 << m_win) : 32'd0);
         chk("model_rsp_valid", 32'(bus.rsp_valid), 32'(m_age >= 3));
         chk("model_busy",      32'(bus.busy),      32'(m_age != 0));
         chk("model_rsp_id",    32'(bus.rsp_id),    32'(m_win));
         chk("model_rsp_data",  32'(bus.rsp_data),  32'(m_data));
      end
      if (!rst_n) begin
         m_on = 1'b1; m_age = 0; m_ptr = 0; m_win = 0; m_data = '0;
      end else if (m_on) begin
         if (m_age == 0) begin
            if (bus.req != '0) begin
               for (int k = N - 1; k >= 0; k--)
                  if (bus.req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
               m_age = 1;
            end
         end else if (m_age == 1) begin
            m_op  = int'(bus.op[2*m_win +: 2]);
            m_a   = bus.a[W*m_win +: W];
            m_b   = bus.b[W*m_win +: W];
            m_age = 2;
         end else if (m_age == 2) begin
            m_data = ref_op(m_op, m_a, m_b);
            m_age  = 3;
         end else if (bus.rsp_ready) begin
            m_ptr = (m_win + 1) % N;
            m_age = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
      bus.op[2*i +: 2] = o;
      bus.a[W*i +: W]  = av;
      bus.b[W*i +: W]  = bv;
   endtask

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] one;
      one = 1;
      return one << i;
   endfunction

   task automatic run_one(input string tag, input int i, input logic [1:0] o,
                          input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] exp);
      step();
      drive(i, o, av, bv);
      bus.req = onehot(i);
      @(negedge clk); chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      step();
      @(negedge clk); chk({tag, "_gnt"}, 32'(bus.gnt), 32'(onehot(i)));
      step();
      bus.req = '0;
      @(negedge clk); chk({tag, "_exec_gnt"}, 32'(bus.gnt), 32'd0);
                      chk({tag, "_exec_busy"}, 32'(bus.busy), 32'd1);
      step();
      @(negedge clk); chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
                      chk({tag, "_id"},    32'(bus.rsp_id),    32'(i));
                      chk({tag, "_data"},  32'(bus.rsp_data),  32'(exp));
      step();
      @(negedge clk); chk({tag, "_valid_fall"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   int q_idx[$];
   int q_cyc[$];
   int exp_order[6] = '{0, 1, 2, 3, 0, 1};

   initial begin
      rst_n         = 1'b0;
      bus.req       = '0;
      bus.op        = '0;
      bus.a         = '0;
      bus.b         = '0;
      bus.rsp_ready = 1'b1;

      // reset then idle
      step();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_gnt",   32'(bus.gnt),       32'd0);
         chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
         chk("rst_busy",  32'(bus.busy),      32'd0);
         chk("rst_id",    32'(bus.rsp_id),    32'd0);
         chk("rst_data",  32'(bus.rsp_data),  32'd0);
         step();
      end
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); chk("idle_busy", 32'(bus.busy), 32'd0);
         step();
      end

      run_one("single", 2, OP_AND,  8'hF0, 8'h3C, 8'h30);
      run_one("and",    0, OP_AND,  8'hA5, 8'h0F, 8'h05);
      run_one("or",     0, OP_OR,   8'hA5, 8'h0F, 8'hAF);
      run_one("nand",   0, OP_NAND, 8'hA5, 8'h0F, 8'hFA);
      run_one("xor",    0, OP_XOR,  8'hA5, 8'h0F, 8'hAA);

      // fairness and wrap, starting from pointer 0
      step(); rst_n = 1'b0;
      step(); rst_n = 1'b1;
      step();
      for (int i = 0; i < N; i++) drive(i, 2'(i), 8'(8'h11 * (i + 1)), 8'h0F);
      bus.req = '1;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if (bus.gnt[i]) begin q_idx.push_back(i); q_cyc.push_back(c); end
         step();
      end
      bus.req = '0;
      chk("fair_count", 32'(q_idx.size()), 32'd6);
      for (int k = 0; k < 6 && k < q_idx.size(); k++) begin
         chk("fair_order", 32'(q_idx[k]), 32'(exp_order[k]));
         if (k > 0) chk("fair_spacing", 32'(q_cyc[k] - q_cyc[k-1]), 32'd4);
      end

      // backpressure: pointer is 2 here, requester 1 wins by wrapping
      bus.rsp_ready = 1'b0;
      drive(1, OP_XOR, 8'h5A, 8'hFF);
      bus.req = 4'b0010;
      step();
      @(negedge clk); chk("bp_gnt1", 32'(bus.gnt), 32'h2);
      step();
      drive(3, OP_OR, 8'h01, 8'h02);
      bus.req = 4'b1000;
      step();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_data",  32'(bus.rsp_data),  32'hA5);
         chk("bp_id",    32'(bus.rsp_id),    32'd1);
         chk("bp_nognt", 32'(bus.gnt),       32'd0);
         step();
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk); chk("bp_release_valid", 32'(bus.rsp_valid), 32'd1);
      step();
      @(negedge clk); chk("bp_idle_valid", 32'(bus.rsp_valid), 32'd0);
      step();
      @(negedge clk); chk("bp_gnt3", 32'(bus.gnt), 32'h8);
      step(); bus.req = '0;
      step();
      step();

      // leave the pointer at 1 before the mid-transaction reset
      run_one("ptr1", 0, OP_OR, 8'h30, 8'h03, 8'h33);

      step();
      drive(2, OP_AND, 8'hFF, 8'hFF);
      bus.req = 4'b0100;
      step();
      @(negedge clk); chk("mid_gnt2", 32'(bus.gnt), 32'h4);
      step();
      bus.req = '0;
      rst_n   = 1'b0;
      @(negedge clk); chk("mid_exec_busy", 32'(bus.busy), 32'd1);
      step();
      rst_n = 1'b1;
      drive(0, OP_XOR, 8'h0F, 8'hFF);
      drive(1, OP_AND, 8'hFF, 8'h00);
      bus.req = 4'b0011;
      @(negedge clk);
      chk("mid_rst_gnt",   32'(bus.gnt),       32'd0);
      chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_busy",  32'(bus.busy),      32'd0);
      chk("mid_rst_id",    32'(bus.rsp_id),    32'd0);
      chk("mid_rst_data",  32'(bus.rsp_data),  32'd0);
      step();
      @(negedge clk); chk("mid_after_gnt0", 32'(bus.gnt), 32'h1);
      step(); bus.req = '0;
      step();
      @(negedge clk); chk("mid_after_data", 32'(bus.rsp_data), 32'hF0);
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gate_unit_arbiter.md
Name: gate_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit (AND/OR/NAND/XOR) among N_REQ requesters.
- Arbitration is round-robin; the controller handles request capture, one-cycle evaluation and response handshake.
- Sits between requester blocks and the shared gate datapath.
- The gate library provides the primitive cells; this block sequences access to them.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- IDW, 2, requester id width; must equal clog2(N_REQ).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- req  input  N_REQ  per-requester request; bit i from requester i.
- op  input  2*N_REQ  per-requester opcode; slice [2i+1:2i] belongs to requester i.
- a  input  WIDTH*N_REQ  per-requester operand A; slice [WIDTH*i +: WIDTH].
- b  input  WIDTH*N_REQ  per-requester operand B; same slicing as a.
- gnt  output  N_REQ  one-hot single-cycle grant; operands of the granted requester are captured that cycle.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of the requester owning the result.
- rsp_data  output  WIDTH  result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; round-robin pointer goes to 0.
  - gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - Reset mid-transaction drops the captured request and any pending response with no grant or response emitted.
- Opcodes:
  - 2'b00 AND, 2'b01 OR, 2'b10 NAND, 2'b11 XOR.
  - All are bitwise over WIDTH bits.
- FSM IDLE → GRANT → EXEC → RESP → IDLE:
  - IDLE:
    - If req has any bit set, the picker selects the first set bit at or after the pointer, wrapping modulo N_REQ.
    - Next state GRANT; winner index is registered.
    - With no requests, stay in IDLE.
  - GRANT:
    - gnt[winner]=1 for exactly this cycle.
    - op, a and b of the winner are registered at the end of the cycle.
    - Next state EXEC.
  - EXEC:
    - rsp_data is computed from the captured operands and registered.
    - rsp_id=winner.
    - Next state RESP.
  - RESP:
    - rsp_valid=1, with rsp_data and rsp_id held stable.
    - When rsp_valid && rsp_ready at a clk edge: the pointer advances to (winner+1) mod N_REQ, the next state is IDLE, and rsp_valid falls.
- Latency: first request cycle in IDLE to rsp_valid is 3 cycles. Back-to-back throughput is one transaction per 4 cycles with rsp_ready tied high.
- Requester rule: hold req and stable operands until gnt is seen; deassert req the cycle after gnt unless issuing a new request.
  - req dropped before gnt is a protocol violation. The block still grants the registered winner and captures whatever operands are present.
- Simultaneous requests: only the round-robin winner is granted; the others wait.
  - A requester granted once is lowest priority in the next arbitration.
  - No requester waits more than N_REQ-1 transactions.
- Pointer wrap: a winner of N_REQ-1 sets the pointer to 0.
- req changes during GRANT/EXEC/RESP are ignored until the next return to IDLE.
- rsp_ready held low keeps RESP indefinitely (backpressure) with the outputs stable; no new grants are issued.
- busy = (state != IDLE).
- gnt is never more than one-hot and is never asserted outside GRANT.

Decomposition:
- Shared package gate_arb_pkg:
  - opcode constants OP_AND, OP_OR, OP_NAND, OP_XOR;
  - FSM state encoding (IDLE=0, GRANT=1, EXEC=2, RESP=3);
  - the function computing a bitwise op from opcode and operands.
- One sub-module rr_picker: combinational.
  - Inputs: req[N_REQ-1:0] and pointer[IDW-1:0].
  - Outputs: found and idx[IDW-1:0].
  - Unit-testable standalone.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, req=0 → gnt=0, rsp_valid=0, busy=0 every cycle.
- Single request:
  - Stimulus: req=4'b0100, op[5:4]=00, a[23:16]=8'hF0, b[23:16]=8'h3C, rsp_ready=1.
  - Expected: gnt=4'b0100 for one cycle; 3 cycles after req, rsp_valid=1, rsp_id=2, rsp_data=8'h30.
- All opcodes on requester 0 with a=8'hA5, b=8'h0F:
  - AND → 8'h05; OR → 8'hAF; NAND → 8'hFA; XOR → 8'hAA.
- Fairness and wrap: req=4'b1111 held continuously, rsp_ready=1 → grant order 0,1,2,3,0,1. Each rsp_id matches its grant and the spacing is 4 cycles.
- Backpressure: request from requester 1 with rsp_ready=0 for 5 cycles.
  - rsp_valid stays 1 with data/id stable and req=4'b1000 is not granted.
  - After rsp_ready=1, requester 3 is granted.
- Reset mid-operation: rst_n=0 in EXEC → next cycle all outputs 0, pointer 0. After release, req=4'b0011 grants requester 0 first.
